// File: rtl/stream_mux_n_pkg.sv
// Shared constants for the N-channel stream multiplexer and its bench.
package stream_mux_pkg;

    localparam int unsigned MODE_SEL = 0;  // external select picks the channel
    localparam int unsigned MODE_RR  = 1;  // round-robin among valid channels

    // Select/index width for an N-channel mux; one bit minimum.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_mux_n_if.sv
// Producer-side and consumer-side stream signals of the multiplexer.
interface stream_mux_n_if
    import stream_mux_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned SELW = sel_width(N);

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [SELW-1:0]    sel;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [SELW-1:0]    out_chan;

    // Multiplexer side
    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_valid, out_chan
    );

    // Environment side: producers, select source and consumer
    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_valid, out_chan
    );

endinterface

// File: rtl/stream_mux_n_rr_arb.sv
// Round-robin arbiter: first requester after ptr, wrapping N-1 -> 0.
module rr_arb_n
    import stream_mux_pkg::*;
#(
    parameter int unsigned N = 4
)(
    input  logic [N-1:0]                 req,
    input  logic [sel_width(N)-1:0]      ptr,
    input  logic                         en,
    output logic [N-1:0]                 gnt_onehot,
    output logic [sel_width(N)-1:0]      gnt_idx
);
    localparam int unsigned SELW = sel_width(N);

    logic [SELW-1:0] cand;
    logic            found;

    // Search ptr+1, ptr+2, ... mod N and grant the first valid request
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        cand       = '0;
        found      = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = SELW'((32'(ptr) + k) % N);
            if (en && !found && req[cand]) begin
                found            = 1'b1;
                gnt_onehot[cand] = 1'b1;
                gnt_idx          = cand;
            end
        end
    end

endmodule

// File: rtl/stream_mux_n.sv
// N-channel registered stream multiplexer with select or round-robin grant.
module stream_mux_n
    import stream_mux_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MODE  = MODE_SEL
)(
    input  logic           clk,
    input  logic           rst,
    stream_mux_n_if.slave  bus
);
    localparam int unsigned SELW = sel_width(N);

    logic             slot_free_c;
    logic             gnt_vld_c;
    logic [SELW-1:0]  gnt_idx_c;
    logic             xfer_c;
    logic [N-1:0]     in_ready_c;
    logic [WIDTH-1:0] gnt_word_c;

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  out_chan_q,  out_chan_d;

    // Output register can take a word when empty or being drained this cycle
    assign slot_free_c = !out_valid_q || bus.out_ready;

    if (MODE == MODE_RR) begin : g_rr
        logic [SELW-1:0] ptr_q, ptr_d;
        logic [N-1:0]    arb_onehot;
        logic [SELW-1:0] arb_idx;
        logic            unused_sel;

        rr_arb_n #(.N(N)) u_arb (
            .req        (bus.in_valid),
            .ptr        (ptr_q),
            .en         (slot_free_c),
            .gnt_onehot (arb_onehot),
            .gnt_idx    (arb_idx)
        );

        assign gnt_vld_c  = |arb_onehot;
        assign gnt_idx_c  = arb_idx;
        assign unused_sel = ^bus.sel;

        // Priority pointer moves to the granted channel, only on a transfer
        always_comb begin
            ptr_d = ptr_q;
            if (xfer_c) begin
                ptr_d = arb_idx;
            end
        end

        // Pointer register; reset gives channel 0 first priority
        always_ff @(posedge clk) begin
            if (rst) begin
                ptr_q <= SELW'(N - 1);
            end else begin
                ptr_q <= ptr_d;
            end
        end
    end else begin : g_sel
        logic sel_req;

        // Valid of the selected channel; out-of-range select never requests
        always_comb begin
            sel_req = 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                if (32'(bus.sel) == i) begin
                    sel_req = bus.in_valid[i];
                end
            end
        end

        assign gnt_vld_c = slot_free_c && sel_req;
        assign gnt_idx_c = bus.sel;
    end

    assign xfer_c = gnt_vld_c && !rst;

    // One-hot ready toward the granted producer only
    always_comb begin
        in_ready_c = '0;
        if (xfer_c) begin
            in_ready_c[gnt_idx_c] = 1'b1;
        end
    end

    // Data word of the granted channel
    always_comb begin
        gnt_word_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (32'(gnt_idx_c) == i) begin
                gnt_word_c = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next output state: load on transfer, drop valid when drained, else hold
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        if (xfer_c) begin
            out_valid_d = 1'b1;
            out_data_d  = gnt_word_c;
            out_chan_d  = gnt_idx_c;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register; reset discards any held word
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: round-robin N=4, select N=4, select N=5 side by side.
module tb_stream_mux_n;
    import stream_mux_pkg::*;

    logic clk;
    logic rst;

    int total = 0;
    int bad   = 0;

    stream_mux_n_if #(.N(4), .WIDTH(8)) if_a ();
    stream_mux_n_if #(.N(4), .WIDTH(8)) if_b ();
    stream_mux_n_if #(.N(5), .WIDTH(8)) if_c ();

    stream_mux_n #(.N(4), .WIDTH(8), .MODE(MODE_RR))  dut_a (.clk(clk), .rst(rst), .bus(if_a));
    stream_mux_n #(.N(4), .WIDTH(8), .MODE(MODE_SEL)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
    stream_mux_n #(.N(5), .WIDTH(8), .MODE(MODE_SEL)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state per DUT: output register contents and priority pointer
    typedef struct {
        int v;
        int d;
        int c;
        int p;
    } mdl_t;

    int   n_of    [3] = '{4, 4, 5};
    int   rr_of   [3] = '{1, 0, 0};
    mdl_t m       [3];
    int   gs      [3];

    logic [63:0] drv_data  [3];
    int          drv_valid [3];
    int          drv_sel   [3];
    int          drv_ordy  [3];

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Which channel should be accepted this cycle, -1 for none
    function automatic int grant_of(input int i);
        int nn;
        nn = n_of[i];
        if (rst) return -1;
        if (m[i].v != 0 && drv_ordy[i] == 0) return -1;
        if (rr_of[i] == 0) begin
            if (drv_sel[i] < nn && ((drv_valid[i] >> drv_sel[i]) & 1) != 0) return drv_sel[i];
            return -1;
        end
        for (int k = 1; k <= nn; k++) begin
            int c;
            c = (m[i].p + k) % nn;
            if (((drv_valid[i] >> c) & 1) != 0) return c;
        end
        return -1;
    endfunction

    function automatic logic [63:0] obs(input int i, input int what);
        logic [63:0] r;
        r = '0;
        case (i)
            0: case (what)
                0: r = 64'(if_a.in_ready);
                1: r = 64'(if_a.out_valid);
                2: r = 64'(if_a.out_data);
                default: r = 64'(if_a.out_chan);
            endcase
            1: case (what)
                0: r = 64'(if_b.in_ready);
                1: r = 64'(if_b.out_valid);
                2: r = 64'(if_b.out_data);
                default: r = 64'(if_b.out_chan);
            endcase
            default: case (what)
                0: r = 64'(if_c.in_ready);
                1: r = 64'(if_c.out_valid);
                2: r = 64'(if_c.out_data);
                default: r = 64'(if_c.out_chan);
            endcase
        endcase
        return r;
    endfunction

    task automatic apply();
        if_a.in_data   = 32'(drv_data[0]);
        if_a.in_valid  = 4'(drv_valid[0]);
        if_a.sel       = 2'(drv_sel[0]);
        if_a.out_ready = 1'(drv_ordy[0]);
        if_b.in_data   = 32'(drv_data[1]);
        if_b.in_valid  = 4'(drv_valid[1]);
        if_b.sel       = 2'(drv_sel[1]);
        if_b.out_ready = 1'(drv_ordy[1]);
        if_c.in_data   = 40'(drv_data[2]);
        if_c.in_valid  = 5'(drv_valid[2]);
        if_c.sel       = 3'(drv_sel[2]);
        if_c.out_ready = 1'(drv_ordy[2]);
    endtask

    // One clock: check ready mid-cycle, advance model at the edge, check outputs after it
    task automatic step();
        apply();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            gs[i] = grant_of(i);
            chk($sformatf("in_ready%0d", i), obs(i, 0),
                (gs[i] >= 0) ? (64'd1 << gs[i]) : 64'd0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m[i].v = 0;
                m[i].d = 0;
                m[i].c = 0;
                m[i].p = n_of[i] - 1;
            end else if (gs[i] >= 0) begin
                m[i].v = 1;
                m[i].d = int'((drv_data[i] >> (8 * gs[i])) & 64'hff);
                m[i].c = gs[i];
                if (rr_of[i] != 0) m[i].p = gs[i];
            end else if (drv_ordy[i] != 0) begin
                m[i].v = 0;
            end
            chk($sformatf("out_valid%0d", i), obs(i, 1), 64'(m[i].v));
            chk($sformatf("out_data%0d", i),  obs(i, 2), 64'(m[i].d));
            chk($sformatf("out_chan%0d", i),  obs(i, 3), 64'(m[i].c));
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m[i].v = 0; m[i].d = 0; m[i].c = 0; m[i].p = n_of[i] - 1;
            drv_data[i] = 64'h0706050403020100;
            drv_valid[i] = (1 << n_of[i]) - 1;
            drv_sel[i] = 0;
            drv_ordy[i] = 1;
        end

        // Reset held two cycles with every channel valid
        rst = 1'b1;
        step();
        step();
        chk("rst_valid", 64'(if_a.out_valid), 64'd0);
        chk("rst_data",  64'(if_a.out_data),  64'd0);
        chk("rst_chan",  64'(if_a.out_chan),  64'd0);

        // RR all valid; select on channel 2; out-of-range select on N=5
        rst = 1'b0;
        drv_data[0]  = 64'h44332211;
        drv_valid[0] = 4'b1111;
        drv_data[1]  = 64'h00A50000;
        drv_valid[1] = 4'b0100;
        drv_sel[1]   = 2;
        drv_valid[2] = 5'b11111;
        drv_sel[2]   = 5;
        for (int j = 0; j < 8; j++) begin
            step();
            chk("rr_seq",   64'(if_a.out_chan),  64'(j % 4));
            chk("rr_full",  64'(if_a.out_valid), 64'd1);
            chk("sel2_data", 64'(if_b.out_data), 64'hA5);
            chk("sel2_chan", 64'(if_b.out_chan), 64'd2);
            chk("sel5_idle", 64'(if_c.out_valid), 64'd0);
        end

        // RR with channels 1 and 3, consumer stalling every other cycle
        drv_valid[0] = 4'b1010;
        for (int j = 0; j < 8; j++) begin
            drv_ordy[0] = (j % 2 == 0) ? 1 : 0;
            step();
            chk("rr_alt", 64'(if_a.out_chan), ((j / 2) % 2 == 0) ? 64'd1 : 64'd3);
            chk("rr_alt_v", 64'(if_a.out_valid), 64'd1);
        end

        // Reset while a word is stalled, then check priority restarts at channel 0
        drv_valid[0] = 4'b1111;
        drv_ordy[0]  = 0;
        rst = 1'b1;
        step();
        chk("rst_mid_v", 64'(if_a.out_valid), 64'd0);
        rst = 1'b0;
        drv_ordy[0] = 1;
        step();
        chk("rst_mid_chan", 64'(if_a.out_chan), 64'd0);
        chk("rst_mid_data", 64'(if_a.out_data), 64'h11);

        // Random traffic against the model
        for (int j = 0; j < 400; j++) begin
            rst = ($urandom_range(0, 99) < 3);
            for (int i = 0; i < 3; i++) begin
                drv_data[i]  = {$urandom, $urandom};
                drv_valid[i] = int'($urandom_range(0, (1 << n_of[i]) - 1));
                drv_sel[i]   = int'($urandom_range(0, (i == 2) ? 7 : 3));
                drv_ordy[i]  = ($urandom_range(0, 9) < 7) ? 1 : 0;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
